q24_8_dot_sequencer: RTL and testbench

//   Sequences one shared Q24.8 multiplier to evaluate a linear-regression prediction
//   y = bias + sum(x[i]*w[i]), for i = 0..N_FEATURES-1.

---
 rtl/q24_8_dot_sequencer.sv | 96 +++++++++
 tb/tb_q24_8_dot_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/q24_8_dot_sequencer.sv
// q24_8_dot_sequencer: drives a shared Q24.8 multiplier to compute bias + sum(x[i]*w[i]) with a saturated result
module q24_8_dot_sequencer #(
  parameter int N_FEATURES = 4,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       bias_in,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       x_data,
  input  logic [31:0]       w_data,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [55:0]       mul_p,
  input  logic              mul_ovf,
  output logic [31:0]       y_out,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              sat
);
  typedef enum logic [2:0] {IDLE, FETCH, MUL, ACC, RESULT} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_FEATURES - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic signed [63:0] acc, prod_ext, acc_sum;
  logic ovf_sticky, add_ovf, last, clamp_hi, clamp_lo;
  assign prod_ext = {{8{mul_p[55]}}, mul_p};
  assign acc_sum  = acc + prod_ext;
  assign add_ovf  = (acc[63] == prod_ext[63]) && (acc_sum[63] != acc[63]);
  assign last     = idx == LAST;
  assign clamp_hi = acc > 64'sh0000_0000_7FFF_FFFF;
  assign clamp_lo = acc < -64'sh0000_0000_8000_0000;
  assign rd_en    = state == FETCH;
  assign rd_addr  = rd_en ? idx : '0;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next-state: one fetch/multiply/accumulate pass per feature, then hold the result until taken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FETCH : IDLE;
      FETCH:   state_nx = MUL;
      MUL:     state_nx = ACC;
      ACC:     state_nx = last ? RESULT : FETCH;
      RESULT:  state_nx = (y_valid && y_ready) ? IDLE : RESULT;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: operand capture, accumulation, and a result registered once in the first RESULT cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx        <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      busy       <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      y_out      <= '0;
      y_valid    <= 1'b0;
      sat        <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            acc        <= {{32{bias_in[31]}}, bias_in};
            idx        <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b1;
          end
        MUL: begin
          mul_a <= x_data;
          mul_b <= w_data;
        end
        ACC: begin
          acc        <= acc_sum;
          ovf_sticky <= ovf_sticky | mul_ovf | add_ovf;
          if (!last) idx <= idx + 1'b1;
        end
        RESULT:
          if (!y_valid) begin
            y_valid <= 1'b1;
            y_out   <= clamp_hi ? 32'h7FFF_FFFF : clamp_lo ? 32'h8000_0000 : acc[31:0];
            sat     <= clamp_hi | clamp_lo | ovf_sticky;
          end else if (y_ready) begin
            y_valid <= 1'b0;
            busy    <= 1'b0;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_q24_8_dot_sequencer.sv
// tb_q24_8_dot_sequencer: scoreboard bench with register-file and multiplier models around the sequencer
module tb_q24_8_dot_sequencer;
  localparam int N = 4;
  localparam int AW = 4;
  typedef struct packed {logic s; logic [31:0] y;} res_t;
  logic clk = 0, rst = 1, start = 0, y_ready = 0, mul_ovf = 0;
  logic [31:0] bias_in = 0, x_data = 0, w_data = 0;
  logic busy, rd_en, y_valid, sat;
  logic [AW-1:0] rd_addr;
  logic [31:0] mul_a, mul_b, y_out;
  logic [55:0] mul_p;
  logic signed [63:0] prod;
  logic [31:0] x_mem [N];
  logic [31:0] w_mem [N];
  res_t exp_q [$];
  int vectors = 0, miscompares = 0;
  int exp_addr = 0, rd_cnt = 0;
  logic have_prev = 0, prev_sat = 0;
  logic [31:0] prev_y = 0;

  q24_8_dot_sequencer #(.N_FEATURES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .x_data(x_data), .w_data(w_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_ovf(mul_ovf),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .sat(sat)
  );

  always #5 clk = ~clk;

  assign prod  = $signed(mul_a) * $signed(mul_b);
  assign mul_p = prod[63:8];

  // register file with one cycle of read latency
  always @(posedge clk)
    if (rd_en && int'(rd_addr) < N) begin
      x_data <= x_mem[rd_addr];
      w_data <= w_mem[rd_addr];
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic res_t model(input logic [31:0] bias, input logic inj);
    longint acc;
    res_t r;
    acc = longint'($signed(bias));
    for (int i = 0; i < N; i++)
      acc += (longint'($signed(x_mem[i])) * longint'($signed(w_mem[i]))) >>> 8;
    if (acc > 64'sd2147483647) r.y = 32'h7FFF_FFFF;
    else if (acc < -64'sd2147483648) r.y = 32'h8000_0000;
    else r.y = acc[31:0];
    r.s = inj || acc > 64'sd2147483647 || acc < -64'sd2147483648;
    return r;
  endfunction

  // monitor: address sequence, result stability, and scoreboard pops on each handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 0;
      rd_cnt = 0;
      have_prev = 0;
    end else begin
      if (rd_en) begin
        chk("rd_addr", 64'(rd_addr), 64'(exp_addr));
        exp_addr = (exp_addr + 1) % N;
        rd_cnt++;
      end
      if (y_valid) begin
        chk("rd_en_in_result", 64'(rd_en), 0);
        chk("busy_in_result", 64'(busy), 1);
        if (have_prev) begin
          chk("y_hold", 64'(y_out), 64'(prev_y));
          chk("sat_hold", 64'(sat), 64'(prev_sat));
        end
        have_prev = 1;
        prev_y = y_out;
        prev_sat = sat;
        if (y_ready) begin
          res_t e;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got %0h expected none", y_out);
          end else begin
            e = exp_q.pop_front();
            chk("y_out", 64'(y_out), 64'(e.y));
            chk("sat", 64'(sat), 64'(e.s));
          end
          chk("rd_count", 64'(rd_cnt), 64'(N));
          rd_cnt = 0;
          have_prev = 0;
        end
      end
    end
  end

  task automatic run(input logic [31:0] bias, input logic inj, input int hold, input logic hs_start);
    int e;
    mul_ovf = inj;
    exp_q.push_back(model(bias, inj));
    y_ready = (hold == 0);
    @(negedge clk);
    start = 1;
    bias_in = bias;
    @(posedge clk);
    #1;
    start = 0;
    bias_in = $urandom;
    e = 1;
    while (!y_valid && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("latency", 64'(e - 1), 64'(3 * N + 1));
    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      @(posedge clk);
      #1;
    end
    start = hs_start;
    y_ready = 1;
    @(posedge clk);
    #1;
    start = 0;
    y_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after", {61'b0, busy, y_valid, rd_en}, 0);
    mul_ovf = 0;
  endtask

  task automatic fill(input logic [31:0] x, input logic [31:0] w);
    for (int i = 0; i < N; i++) begin
      x_mem[i] = x;
      w_mem[i] = w;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    return ($urandom % 4 == 0) ? 32'($urandom) : 32'($urandom_range(0, 32767) - 16384);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, rd_en, rd_addr, mul_a, mul_b, y_out, y_valid, sat}, 0);
    @(negedge clk);
    rst = 0;
    fill(32'h100, 32'h200);
    run(32'h80, 0, 0, 0);
    chk("case1_value", 64'(y_out), 64'h880);
    fill(32'hFFFF_FF00, 32'h100);
    run(32'h0, 0, 0, 0);
    chk("case2_value", 64'(y_out), 64'hFFFF_FC00);
    fill(32'h0, 32'h0);
    x_mem[0] = 32'h7FFF_FFFF;
    w_mem[0] = 32'h1_0000;
    run(32'h0, 0, 1, 0);
    chk("case3_pos", {sat, y_out}, {1'b1, 32'h7FFF_FFFF});
    x_mem[0] = 32'h8000_0000;
    run(32'h0, 0, 0, 1);
    chk("case3_neg", {sat, y_out}, {1'b1, 32'h8000_0000});
    fill(32'h300, 32'hFFFF_FE00);
    run(32'h1234, 0, 5, 0);
    fill(32'h100, 32'h100);
    run(32'h0, 1, 2, 0);
    fill(32'h100, 32'h200);
    y_ready = 1;
    @(negedge clk);
    start = 1;
    bias_in = 32'h80;
    @(posedge clk);
    #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("midop_reset", {busy, rd_en, rd_addr, mul_a, mul_b, y_out, y_valid, sat}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    y_ready = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_result_after_abort", {62'b0, busy, y_valid}, 0);
    run(32'h80, 0, 0, 0);
    chk("case1_after_reset", {sat, y_out}, {1'b0, 32'h880});
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        x_mem[i] = rnd_val();
        w_mem[i] = rnd_val();
      end
      run(rnd_val(), ($urandom % 8) == 0, int'($urandom % 4), 1'($urandom % 2));
    end
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
